// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: lap FSM state and BCD lap record.
// Imported by lap_controller and lap_buffer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    FREEZE = 2'd1,
    RECALL = 2'd2
  } lap_state_t;

  typedef struct packed {
    logic [3:0] s10;
    logic [3:0] s1;
    logic [3:0] ms100;
    logic [3:0] ms10;
  } lap_time_t;

endpackage

// File: rtl/lap_buffer.sv
// DEPTH-entry ring store of lap times with write/oldest pointers and count.
// Ports: clk, rst, clr, wr, wr_data in; rd_off (from oldest) in; rd_data, count, full, empty out.
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  lap_time_t     wr_data,
  input  logic [PW-1:0] rd_off,
  output lap_time_t     rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  lap_time_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] old_ptr;
  logic [PW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // DEPTH is a power of two, so pointer sums wrap naturally
  assign rd_ptr  = old_ptr + rd_off;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      old_ptr <= '0;
      count   <= '0;
    end else if (wr) begin
      wr_ptr <= wr_ptr + PW'(1);
      // a write while full replaces the oldest entry
      if (full)
        old_ptr <= old_ptr + PW'(1);
      else
        count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lap_controller.sv
// Stopwatch lap capture/freeze/recall controller with registered BCD display.
// Ports: clk100_i, rst_i, lap/recall/clear pulses, running_i, live digits in;
// display digits, lap_idx_o, lap_count_o, empty_o, full_o, recall_o out.
// Define LAP_OVERWRITE_EN to let a capture while full replace the oldest lap.
module lap_controller
  import stopwatch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                     clk100_i,
  input  logic                     rst_i,
  input  logic                     lap_s_i,
  input  logic                     recall_s_i,
  input  logic                     clear_s_i,
  input  logic                     running_i,
  input  logic [3:0]               ms10_i,
  input  logic [3:0]               ms100_i,
  input  logic [3:0]               s1_i,
  input  logic [3:0]               s10_i,
  output logic [3:0]               ms10_o,
  output logic [3:0]               ms100_o,
  output logic [3:0]               s1_o,
  output logic [3:0]               s10_o,
  output logic [$clog2(DEPTH):0]   lap_idx_o,
  output logic [$clog2(DEPTH):0]   lap_count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     recall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = PW + 1;
  localparam int TW = $clog2(HOLD_CYCLES + 1);

`ifdef LAP_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  lap_state_t    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [PW-1:0] rec_off, rec_off_n;
  logic          cap;
  logic          cap_ok;
  logic [IW-1:0] count;
  logic [IW-1:0] last;
  logic          full, empty;
  logic [PW-1:0] rd_off;
  lap_time_t     live, rd_data, disp;
  logic [IW-1:0] idx;

  assign live = {s10_i, s1_i, ms100_i, ms10_i};
  assign last = count - IW'(1);

  assign cap_ok = lap_s_i && running_i && (!full || OVW);

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    rec_off_n = rec_off;
    cap       = 1'b0;
    if (clear_s_i) begin
      state_n   = LIVE;
      timer_n   = '0;
      rec_off_n = '0;
    end else begin
      unique case (state)
        LIVE: begin
          if (cap_ok) begin
            cap     = 1'b1;
            state_n = FREEZE;
            timer_n = TW'(HOLD_CYCLES - 1);
          end else if (recall_s_i && !empty) begin
            state_n   = RECALL;
            rec_off_n = '0;
          end
        end
        FREEZE: begin
          if (cap_ok) begin
            cap     = 1'b1;
            timer_n = TW'(HOLD_CYCLES - 1);
          end else if (timer == '0) begin
            state_n = LIVE;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
        RECALL: begin
          if (recall_s_i) begin
            if ({1'b0, rec_off} == last) begin
              state_n   = LIVE;
              rec_off_n = '0;
            end else begin
              rec_off_n = rec_off + PW'(1);
            end
          end
        end
        default: state_n = LIVE;
      endcase
    end
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      state   <= LIVE;
      timer   <= '0;
      rec_off <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      rec_off <= rec_off_n;
    end
  end

  // FREEZE shows the newest lap; RECALL walks from the oldest
  assign rd_off = (state == RECALL) ? rec_off : last[PW-1:0];

  lap_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk100_i),
    .rst     (rst_i),
    .clr     (clear_s_i),
    .wr      (cap && !rst_i),
    .wr_data (live),
    .rd_off  (rd_off),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      disp <= '0;
      idx  <= '0;
    end else begin
      unique case (state)
        FREEZE: begin
          disp <= rd_data;
          idx  <= count;
        end
        RECALL: begin
          disp <= rd_data;
          idx  <= {1'b0, rec_off} + IW'(1);
        end
        default: begin
          disp <= live;
          idx  <= '0;
        end
      endcase
    end
  end

  assign s10_o       = disp.s10;
  assign s1_o        = disp.s1;
  assign ms100_o     = disp.ms100;
  assign ms10_o      = disp.ms10;
  assign lap_idx_o   = idx;
  assign lap_count_o = count;
  assign empty_o     = empty;
  assign full_o      = full;
  assign recall_o    = (state == RECALL);

endmodule
